vol_btn_ctrl: RTL and testbench

- Volume/mute controller for the audio path. Turns the two debounced front-panel volume buttons into a saturating volume level, with press-and-hold auto-repeat and a both-buttons-held mute toggle.
- Also accepts a direct volume write from the system CPU.
- Outputs feed the I2S upsampler gain stage and the sys PIO, so firmware can mirror the OSD.

---
 rtl/vol_btn_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_vol_btn_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vol_btn_ctrl.sv
// vol_btn_ctrl: turns the two debounced front-panel volume buttons into a
// saturating volume level with press-and-hold auto-repeat and a
// both-buttons-held mute toggle. A CPU write loads the level directly and
// overrides any button action in the same cycle.
module vol_btn_ctrl #(
    parameter int CLK_DIV     = 20000,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 100,
    parameter int MUTE_MS     = 1000,
    parameter int VOL_BITS    = 4,
    parameter int VOL_MAX     = 15,
    parameter int VOL_DEFAULT = 10
) (
    input  logic                clk_i,
    input  logic                reset_n,
    input  logic                btn_minus_i,
    input  logic                btn_plus_i,
    input  logic                vol_wr_i,
    input  logic [VOL_BITS-1:0] vol_wdata_i,
    output logic [VOL_BITS-1:0] vol_o,
    output logic                mute_o,
    output logic                update_o,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS    = 3'd1,
        ST_REPEAT   = 3'd2,
        ST_BOTH     = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MS_MAX = (HOLD_MS > REPEAT_MS)
                          ? ((HOLD_MS > MUTE_MS) ? HOLD_MS : MUTE_MS)
                          : ((REPEAT_MS > MUTE_MS) ? REPEAT_MS : MUTE_MS);
    localparam int MS_W   = $clog2(MS_MAX + 1);

    localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(CLK_DIV - 1);
    // Intervals fire on the tick that would make the ms counter reach N,
    // so an N ms interval lands exactly N*CLK_DIV cycles after a clear.
    localparam logic [MS_W-1:0]     HOLD_LAST   = MS_W'(HOLD_MS - 1);
    localparam logic [MS_W-1:0]     REPEAT_LAST = MS_W'(REPEAT_MS - 1);
    localparam logic [MS_W-1:0]     MUTE_LAST   = MS_W'(MUTE_MS - 1);
    localparam logic [VOL_BITS-1:0] VMAX        = VOL_BITS'(VOL_MAX);
    localparam logic [VOL_BITS-1:0] VDEF        = VOL_BITS'(VOL_DEFAULT);

    logic                rst_meta_q, rst_sync_q;
    logic [1:0]          sync1_q, sync2_q;          // [1] = plus, [0] = minus
    state_t              state_q, state_d;
    logic                dir_q, dir_d;              // 1 = up
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [MS_W-1:0]     ms_q, ms_d;
    logic [VOL_BITS-1:0] vol_q, vol_d;
    logic                mute_q, mute_d;
    logic                upd_q, upd_d;

    logic                p_minus_s, p_plus_s, act_s, oth_s;
    logic                ms_tick_s, hold_hit_s, rpt_hit_s, mute_hit_s;
    logic                step_s, toggle_s, rpt_clr_s;
    logic [VOL_BITS-1:0] wr_val_s;

    assign p_minus_s  = ~sync2_q[0];
    assign p_plus_s   = ~sync2_q[1];
    assign ms_tick_s  = (pre_q == PRE_LAST);
    assign hold_hit_s = ms_tick_s && (ms_q == HOLD_LAST);
    assign rpt_hit_s  = ms_tick_s && (ms_q == REPEAT_LAST);
    assign mute_hit_s = ms_tick_s && (ms_q == MUTE_LAST);
    assign wr_val_s   = (vol_wdata_i > VMAX) ? VMAX : vol_wdata_i;

    // Reset synchronizer: asserts asynchronously, releases on the clock.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Next state, captured direction and the step/toggle requests.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        step_s    = 1'b0;
        toggle_s  = 1'b0;
        rpt_clr_s = 1'b0;
        act_s     = dir_q ? p_plus_s  : p_minus_s;
        oth_s     = dir_q ? p_minus_s : p_plus_s;
        case (state_q)
            ST_IDLE: begin
                if (p_minus_s && p_plus_s) begin
                    state_d = ST_BOTH;
                end else if (p_minus_s || p_plus_s) begin
                    step_s  = 1'b1;
                    dir_d   = p_plus_s;
                    state_d = ST_PRESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (!act_s) begin
                    state_d = ST_IDLE;
                end else if (oth_s) begin
                    state_d = ST_BOTH;
                end else if (hold_hit_s) begin
                    step_s  = 1'b1;
                    state_d = ST_REPEAT;
                end else begin
                    state_d = ST_PRESS;
                end
            end
            ST_REPEAT: begin
                if (!act_s) begin
                    state_d = ST_IDLE;
                end else if (oth_s) begin
                    state_d = ST_BOTH;
                end else if (rpt_hit_s) begin
                    step_s    = 1'b1;
                    rpt_clr_s = 1'b1;
                end else begin
                    state_d = ST_REPEAT;
                end
            end
            ST_BOTH: begin
                if (!p_minus_s || !p_plus_s) begin
                    state_d = ST_WAIT_REL;
                end else if (mute_hit_s) begin
                    toggle_s = 1'b1;
                    state_d  = ST_WAIT_REL;
                end else begin
                    state_d = ST_BOTH;
                end
            end
            ST_WAIT_REL: begin
                if (!p_minus_s && !p_plus_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Millisecond timer; restarts on every state entry and repeat step.
    always_comb begin
        pre_d = pre_q;
        ms_d  = ms_q;
        if ((state_d != state_q) || rpt_clr_s) begin
            pre_d = {PRE_W{1'b0}};
            ms_d  = {MS_W{1'b0}};
        end else if (ms_tick_s) begin
            pre_d = {PRE_W{1'b0}};
            ms_d  = ms_q + MS_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Volume/mute update: CPU write first, then saturating step, then mute.
    always_comb begin
        vol_d  = vol_q;
        mute_d = mute_q;
        upd_d  = 1'b0;
        if (vol_wr_i) begin
            vol_d = wr_val_s;
            upd_d = 1'b1;
        end else if (step_s) begin
            if (dir_d && (vol_q < VMAX)) begin
                vol_d  = vol_q + VOL_BITS'(1);
                mute_d = 1'b0;
                upd_d  = 1'b1;
            end else if (!dir_d && (vol_q != {VOL_BITS{1'b0}})) begin
                vol_d  = vol_q - VOL_BITS'(1);
                mute_d = 1'b0;
                upd_d  = 1'b1;
            end else begin
                upd_d = 1'b0;
            end
        end else if (toggle_s) begin
            mute_d = ~mute_q;
            upd_d  = 1'b1;
        end else begin
            upd_d = 1'b0;
        end
    end

    // Button synchronizers, FSM, timer and output registers.
    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            pre_q   <= {PRE_W{1'b0}};
            ms_q    <= {MS_W{1'b0}};
            vol_q   <= VDEF;
            mute_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            sync1_q <= {btn_plus_i, btn_minus_i};
            sync2_q <= sync1_q;
            state_q <= state_d;
            dir_q   <= dir_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            vol_q   <= vol_d;
            mute_q  <= mute_d;
            upd_q   <= upd_d;
        end
    end

    assign vol_o    = vol_q;
    assign mute_o   = mute_q;
    assign update_o = upd_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_vol_btn_ctrl.sv
// Bench for vol_btn_ctrl: directed scenarios followed by random button and
// CPU-write traffic, all compared every cycle against a behavioural model
// built from elapsed-cycle arithmetic.
module tb_vol_btn_ctrl;

    localparam int CD   = 4;
    localparam int HOLD = 3;
    localparam int RPT  = 2;
    localparam int MUTE = 5;
    localparam int VB   = 5;
    localparam int VMAX = 15;
    localparam int VDEF = 10;

    logic          clk_i = 1'b0;
    logic          reset_n = 1'b0;
    logic          btn_minus_i = 1'b1;
    logic          btn_plus_i = 1'b1;
    logic          vol_wr_i = 1'b0;
    logic [VB-1:0] vol_wdata_i = '0;
    logic [VB-1:0] vol_o;
    logic          mute_o;
    logic          update_o;
    logic [2:0]    state_o;

    int tests = 0;
    int fails = 0;
    int upd_cnt = 0;

    // model state
    int m_vol, m_st, m_el, m_rcnt;
    bit m_mute, m_upd, m_up;
    bit h1m, h2m, h1p, h2p;

    vol_btn_ctrl #(
        .CLK_DIV(CD), .HOLD_MS(HOLD), .REPEAT_MS(RPT), .MUTE_MS(MUTE),
        .VOL_BITS(VB), .VOL_MAX(VMAX), .VOL_DEFAULT(VDEF)
    ) dut (
        .clk_i(clk_i), .reset_n(reset_n),
        .btn_minus_i(btn_minus_i), .btn_plus_i(btn_plus_i),
        .vol_wr_i(vol_wr_i), .vol_wdata_i(vol_wdata_i),
        .vol_o(vol_o), .mute_o(mute_o), .update_o(update_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vol = VDEF; m_mute = 0; m_upd = 0; m_st = 0; m_el = 0; m_up = 0;
        h1m = 1; h2m = 1; h1p = 1; h2p = 1;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        bit fm, fp, act, oth, step, tog, clr;
        int nst;
        if (!reset_n) begin
            model_reset();
            m_rcnt = 0;
        end else if (m_rcnt < 2) begin
            model_reset();
            m_rcnt++;
        end else begin
            fm = !h2m; fp = !h2p;
            h2m = h1m; h1m = btn_minus_i;
            h2p = h1p; h1p = btn_plus_i;
            nst = m_st; step = 0; tog = 0; clr = 0;
            act = m_up ? fp : fm;
            oth = m_up ? fm : fp;
            if (m_st == 0) begin
                if (fm && fp) nst = 3;
                else if (fm || fp) begin step = 1; m_up = fp; nst = 1; end
            end else if (m_st == 1 || m_st == 2) begin
                if (!act) nst = 0;
                else if (oth) nst = 3;
                else if (m_st == 1 && m_el + 1 == HOLD * CD) begin step = 1; nst = 2; end
                else if (m_st == 2 && m_el + 1 == RPT * CD) begin step = 1; clr = 1; end
            end else if (m_st == 3) begin
                if (!fm || !fp) nst = 4;
                else if (m_el + 1 == MUTE * CD) begin tog = 1; nst = 4; end
            end else begin
                if (!fm && !fp) nst = 0;
            end
            m_upd = 0;
            if (vol_wr_i) begin
                m_vol = (int'(vol_wdata_i) > VMAX) ? VMAX : int'(vol_wdata_i);
                m_upd = 1;
            end else if (step) begin
                if (m_up && m_vol < VMAX) begin m_vol++; m_mute = 0; m_upd = 1; end
                else if (!m_up && m_vol > 0) begin m_vol--; m_mute = 0; m_upd = 1; end
            end else if (tog) begin
                m_mute = !m_mute; m_upd = 1;
            end
            if (nst != m_st || clr) m_el = 0;
            else m_el++;
            m_st = nst;
        end
    endtask

    // Advance one cycle, then compare all outputs at the falling edge.
    task automatic cyc();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check("vol", vol_o, m_vol);
        check("mute", mute_o, m_mute);
        check("upd", update_o, m_upd);
        check("state", state_o, m_st);
        if (update_o === 1'b1) upd_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic cpu_write(input int v);
        vol_wr_i = 1'b1; vol_wdata_i = VB'(v);
        cyc();
        vol_wr_i = 1'b0;
    endtask

    initial begin
        model_reset();
        m_rcnt = 0;
        // reset state
        run(3);
        check("rst_vol", vol_o, 10);
        check("rst_mute", mute_o, 0);
        check("rst_upd", update_o, 0);
        check("rst_state", state_o, 0);
        reset_n = 1'b1;
        run(4);

        // tap vol+: step lands 3 cycles after the pin edge
        btn_plus_i = 1'b0;
        run(2);
        check("tap_early", vol_o, 10);
        cyc();
        check("tap_vol", vol_o, 11);
        check("tap_upd", update_o, 1);
        run(2);
        btn_plus_i = 1'b1;
        run(6);
        check("tap_idle", state_o, 0);

        // hold vol- from 10: steps at press, +12, +20, +28, +36
        cpu_write(10);
        check("wr10", vol_o, 10);
        upd_cnt = 0;
        btn_minus_i = 1'b0;
        run(40);
        check("hold_dn_vol", vol_o, 5);
        check("hold_dn_pulses", upd_cnt, 5);
        btn_minus_i = 1'b1;
        run(6);

        // hold vol+ from 14: saturates at the first step
        cpu_write(14);
        upd_cnt = 0;
        btn_plus_i = 1'b0;
        run(60);
        check("sat_vol", vol_o, 15);
        check("sat_pulses", upd_cnt, 1);
        btn_plus_i = 1'b1;
        run(6);

        // both buttons: mute after 20 cycles in BOTH
        upd_cnt = 0;
        btn_plus_i = 1'b0; btn_minus_i = 1'b0;
        run(25);
        check("mute_on", mute_o, 1);
        check("mute_state", state_o, 4);
        check("mute_pulses", upd_cnt, 1);
        btn_plus_i = 1'b1;
        run(6);
        check("wait_one", state_o, 4);
        btn_minus_i = 1'b1;
        run(6);
        check("wait_idle", state_o, 0);
        cpu_write(7);
        check("wr_keeps_mute", mute_o, 1);
        btn_plus_i = 1'b0;
        run(5);
        btn_plus_i = 1'b1;
        run(6);
        check("unmute_vol", vol_o, 8);
        check("unmute", mute_o, 0);

        // CPU write in the exact hold-step cycle wins and clamps
        btn_plus_i = 1'b0;
        run(14);
        check("pre_wr_vol", vol_o, 9);
        vol_wr_i = 1'b1; vol_wdata_i = VB'(20);
        cyc();
        vol_wr_i = 1'b0;
        check("wr_clamp", vol_o, 15);
        check("wr_upd", update_o, 1);
        check("wr_state", state_o, 2);
        cyc();
        check("wr_single", update_o, 0);

        // asynchronous reset mid-repeat
        run(5);
        reset_n = 1'b0;
        #1;
        check("arst_vol", vol_o, 10);
        check("arst_mute", mute_o, 0);
        check("arst_state", state_o, 0);
        check("arst_upd", update_o, 0);
        model_reset();
        btn_plus_i = 1'b1;
        run(3);
        reset_n = 1'b1;
        upd_cnt = 0;
        run(10);
        check("post_rst_pulses", upd_cnt, 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                btn_minus_i = 1'($urandom_range(0, 1));
                btn_plus_i  = btn_minus_i;
            end else begin
                if ($urandom_range(0, 29) == 0) btn_minus_i = ~btn_minus_i;
                if ($urandom_range(0, 29) == 0) btn_plus_i  = ~btn_plus_i;
            end
            if ($urandom_range(0, 39) == 0) begin
                vol_wr_i = 1'b1;
                vol_wdata_i = VB'($urandom_range(0, 31));
            end else begin
                vol_wr_i = 1'b0;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
